// File: rtl/data_io_pkg.sv
// Shared definitions for the data_io_stream download port: IO-controller
// command codes, control FSM states and the byte-lane helper.
package data_io_pkg;

    localparam logic [7:0] UIO_FILE_TX     = 8'h53;
    localparam logic [7:0] UIO_FILE_TX_DAT = 8'h54;
    localparam logic [7:0] UIO_FILE_INDEX  = 8'h55;

    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        FLUSH,
        DRAIN
    } state_t;

    function automatic int lane_count(input int data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/data_io_fifo.sv
// Synchronous FIFO holding packed {addr, data, mask} write entries.
// Push while full is taken only when a pop frees a slot the same cycle.
module data_io_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_flush,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W:0]   r_wr_ptr;
    logic [PTR_W:0]   r_rd_ptr;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic             w_do_pop;
    logic             w_do_push;

    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                       (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // NOTE: storage has no reset; the pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (w_do_push && !i_flush) r_mem[r_wr_ptr[PTR_W-1:0]] <= i_data;
    end

    assign o_data = r_mem[r_rd_ptr[PTR_W-1:0]];

endmodule

// File: rtl/data_io_stream.sv
// IO-controller file download port: oversampled SPI receiver, command decoder,
// little-endian word packer and control FSM feeding a valid/ready write FIFO.
module data_io_stream
    import data_io_pkg::*;
#(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 8,
    parameter int START_ADDR = 0,
    parameter int FIFO_DEPTH = 4,
    parameter int SIZE_W     = 24
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                sck,
    input  logic                ss,
    input  logic                sdi,
    output logic                downloading,
    output logic [7:0]          index,
    output logic [SIZE_W-1:0]   size,
    output logic                wr_valid,
    input  logic                wr_ready,
    output logic [ADDR_W-1:0]   wr_addr,
    output logic [DATA_W-1:0]   wr_data,
    output logic [DATA_W/8-1:0] wr_mask,
    output logic                overflow
);

    localparam int LANES   = lane_count(DATA_W);
    localparam int LANE_W  = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int ENTRY_W = ADDR_W + DATA_W + LANES;
    localparam logic [ADDR_W-1:0] START = ADDR_W'(START_ADDR);

    logic [1:0]         r_rst_pipe;
    logic               w_rst_n;
    logic [1:0]         r_sck_sync;
    logic [1:0]         r_ss_sync;
    logic [1:0]         r_sdi_sync;
    logic               r_sck_d;
    logic               w_sample;
    logic [7:0]         w_byte;
    logic [2:0]         r_bit_cnt;
    logic [6:0]         r_shift;
    logic               r_cmd_done;
    logic [7:0]         r_cmd;
    logic               r_byte_stb;
    logic [7:0]         r_byte;
    state_t             r_state;
    state_t             w_state_nx;
    logic               w_start;
    logic               w_end;
    logic               w_dat;
    logic               w_index_wr;
    logic               w_flush_push;
    logic               w_word_push;
    logic               w_push;
    logic               w_pop;
    logic [LANE_W-1:0]  r_lane;
    logic [DATA_W-1:0]  r_pack_data;
    logic [DATA_W-1:0]  w_word_data;
    logic [LANES-1:0]   w_flush_mask;
    logic [ADDR_W-1:0]  r_addr;
    logic [SIZE_W-1:0]  r_size;
    logic               r_overflow;
    logic [7:0]         r_index;
    logic [ENTRY_W-1:0] w_push_entry;
    logic [ENTRY_W-1:0] w_head;
    logic [ADDR_W-1:0]  w_head_addr;
    logic [DATA_W-1:0]  w_head_data;
    logic [LANES-1:0]   w_head_mask;
    logic               w_fifo_full;
    logic               w_fifo_empty;

    // Asynchronous assertion, release aligned to clk.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_rst_pipe <= 2'b00;
        else          r_rst_pipe <= {r_rst_pipe[0], 1'b1};
    end
    assign w_rst_n = r_rst_pipe[1];

    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_sck_sync <= 2'b00;
            r_ss_sync  <= 2'b11;
            r_sdi_sync <= 2'b00;
            r_sck_d    <= 1'b0;
        end else begin
            r_sck_sync <= {r_sck_sync[0], sck};
            r_ss_sync  <= {r_ss_sync[0], ss};
            r_sdi_sync <= {r_sdi_sync[0], sdi};
            r_sck_d    <= r_sck_sync[1];
        end
    end

    assign w_sample = r_sck_sync[1] && !r_sck_d && !r_ss_sync[1];
    assign w_byte   = {r_shift, r_sdi_sync[1]};

    // First byte of a frame is the command; every later byte is a parameter strobe.
    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_cmd_done <= 1'b0;
            r_cmd      <= '0;
            r_byte_stb <= 1'b0;
            r_byte     <= '0;
        end else begin
            r_byte_stb <= 1'b0;
            if (r_ss_sync[1]) begin
                r_bit_cnt  <= '0;
                r_cmd_done <= 1'b0;
                r_cmd      <= '0;
            end else if (w_sample) begin
                r_shift   <= w_byte[6:0];
                r_bit_cnt <= r_bit_cnt + 1'b1;
                if (r_bit_cnt == 3'd7) begin
                    if (r_cmd_done) begin
                        r_byte_stb <= 1'b1;
                        r_byte     <= w_byte;
                    end else begin
                        r_cmd      <= w_byte;
                        r_cmd_done <= 1'b1;
                    end
                end
            end
        end
    end

    assign w_start    = r_byte_stb && (r_cmd == UIO_FILE_TX) && r_byte[0];
    assign w_end      = r_byte_stb && (r_cmd == UIO_FILE_TX) && !r_byte[0];
    assign w_dat      = r_byte_stb && (r_cmd == UIO_FILE_TX_DAT) && (r_state == ACTIVE);
    assign w_index_wr = r_byte_stb && (r_cmd == UIO_FILE_INDEX) && (r_state == IDLE);

    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) r_state <= IDLE;
        else          r_state <= w_state_nx;
    end

    // NOTE: defaults first so no path leaves a signal unassigned (no latch inferred).
    always_comb begin
        w_state_nx   = r_state;
        w_flush_push = 1'b0;
        case (r_state)
            ACTIVE: if (w_end) w_state_nx = (r_lane != '0) ? FLUSH : DRAIN;
            FLUSH: begin
                w_flush_push = 1'b1;
                w_state_nx   = DRAIN;
            end
            DRAIN:  if (w_fifo_empty) w_state_nx = IDLE;
            default: w_state_nx = r_state;
        endcase
        if (w_start) begin
            w_state_nx   = ACTIVE;
            w_flush_push = 1'b0;
        end
    end

    always_comb begin
        w_word_data = r_pack_data | (DATA_W'(r_byte) << (8 * r_lane));
        for (int i = 0; i < LANES; i++) w_flush_mask[i] = (i < int'(r_lane));
    end

    assign w_word_push  = w_dat && (r_lane == LANE_W'(LANES - 1));
    assign w_push       = w_word_push || w_flush_push;
    assign w_push_entry = w_flush_push ? {r_addr, r_pack_data, w_flush_mask}
                                       : {r_addr, w_word_data, {LANES{1'b1}}};
    assign w_pop        = wr_valid && wr_ready;

    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_lane      <= '0;
            r_pack_data <= '0;
            r_addr      <= START;
            r_size      <= '0;
            r_overflow  <= 1'b0;
            r_index     <= '0;
        end else begin
            if (w_index_wr) r_index <= r_byte;
            if (w_start) begin
                r_lane      <= '0;
                r_pack_data <= '0;
                r_addr      <= START;
                r_size      <= '0;
                r_overflow  <= 1'b0;
            end else begin
                if (w_dat) begin
                    if (r_size != '1) r_size <= r_size + 1'b1;
                    if (w_word_push) begin
                        r_lane      <= '0;
                        r_pack_data <= '0;
                    end else begin
                        r_lane      <= r_lane + 1'b1;
                        r_pack_data <= w_word_data;
                    end
                end
                if (w_flush_push) begin
                    r_lane      <= '0;
                    r_pack_data <= '0;
                end
                // A dropped word still consumes its address.
                if (w_push) r_addr <= r_addr + 1'b1;
                if (w_push && w_fifo_full && !w_pop) r_overflow <= 1'b1;
            end
        end
    end

    data_io_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (w_rst_n),
        .i_flush (w_start && downloading),
        .i_push  (w_push),
        .i_data  (w_push_entry),
        .i_pop   (wr_ready),
        .o_data  (w_head),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    assign {w_head_addr, w_head_data, w_head_mask} = w_head;

    assign downloading = (r_state != IDLE);
    assign index       = r_index;
    assign size        = r_size;
    assign overflow    = r_overflow;
    assign wr_valid    = !w_fifo_empty;
    assign wr_addr     = wr_valid ? w_head_addr : START;
    assign wr_data     = wr_valid ? w_head_data : '0;
    assign wr_mask     = wr_valid ? w_head_mask : '0;

endmodule

// File: tb/tb_data_io_stream.sv
// Directed bench for data_io_stream: three instances (8-bit, 16-bit, 4-bit
// address wrap) share the SPI pins; ss is gated so only one listens at a time.
module tb_data_io_stream;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_n, sck, ss, sdi;
    logic [1:0] sel;
    logic       ss_8, ss_16, ss_w;
    assign ss_8  = (sel == 2'd0) ? ss : 1'b1;
    assign ss_16 = (sel == 2'd1) ? ss : 1'b1;
    assign ss_w  = (sel == 2'd2) ? ss : 1'b1;

    logic        dl_8, valid_8, ready_8, ovf_8;
    logic [7:0]  idx_8, data_8;
    logic [23:0] size_8;
    logic [15:0] addr_8;
    logic [0:0]  mask_8;

    logic        dl_16, valid_16, ready_16, ovf_16;
    logic [7:0]  idx_16;
    logic [23:0] size_16;
    logic [15:0] addr_16, data_16;
    logic [1:0]  mask_16;

    logic        dl_w, valid_w, ready_w, ovf_w;
    logic [7:0]  idx_w, data_w;
    logic [23:0] size_w;
    logic [3:0]  addr_w;
    logic [0:0]  mask_w;

    data_io_stream u_dut8 (
        .clk(clk), .reset_n(reset_n), .sck(sck), .ss(ss_8), .sdi(sdi),
        .downloading(dl_8), .index(idx_8), .size(size_8),
        .wr_valid(valid_8), .wr_ready(ready_8), .wr_addr(addr_8),
        .wr_data(data_8), .wr_mask(mask_8), .overflow(ovf_8)
    );

    data_io_stream #(.DATA_W(16)) u_dut16 (
        .clk(clk), .reset_n(reset_n), .sck(sck), .ss(ss_16), .sdi(sdi),
        .downloading(dl_16), .index(idx_16), .size(size_16),
        .wr_valid(valid_16), .wr_ready(ready_16), .wr_addr(addr_16),
        .wr_data(data_16), .wr_mask(mask_16), .overflow(ovf_16)
    );

    data_io_stream #(.ADDR_W(4), .START_ADDR(14)) u_dutw (
        .clk(clk), .reset_n(reset_n), .sck(sck), .ss(ss_w), .sdi(sdi),
        .downloading(dl_w), .index(idx_w), .size(size_w),
        .wr_valid(valid_w), .wr_ready(ready_w), .wr_addr(addr_w),
        .wr_data(data_w), .wr_mask(mask_w), .overflow(ovf_w)
    );

    typedef struct packed {
        logic [15:0] addr;
        logic [31:0] data;
        logic [3:0]  mask;
    } wr_t;

    wr_t q8[$];
    wr_t q16[$];
    wr_t qw[$];

    int checks = 0;
    int errors = 0;

    // Handshakes are recorded mid-cycle; inputs only change 2ns after posedge.
    always @(negedge clk) begin
        if (valid_8 === 1'b1 && ready_8 === 1'b1)
            q8.push_back({addr_8, 32'(data_8), 4'(mask_8)});
        if (valid_16 === 1'b1 && ready_16 === 1'b1)
            q16.push_back({addr_16, 32'(data_16), 4'(mask_16)});
        if (valid_w === 1'b1 && ready_w === 1'b1)
            qw.push_back({16'(addr_w), 32'(data_w), 4'(mask_w)});
    end

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic spi_bit(input logic b);
        sdi = b;
        wait_clks(4);
        sck = 1'b1;
        wait_clks(4);
        sck = 1'b0;
    endtask

    task automatic spi_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) spi_bit(b[i]);
    endtask

    task automatic frame_open(input logic [7:0] cmd);
        ss = 1'b0;
        wait_clks(4);
        spi_byte(cmd);
    endtask

    task automatic frame_close();
        wait_clks(4);
        ss = 1'b1;
        wait_clks(6);
    endtask

    task automatic send_index(input logic [7:0] v);
        frame_open(8'h55);
        spi_byte(v);
        frame_close();
    endtask

    task automatic send_start();
        frame_open(8'h53);
        spi_byte(8'h01);
        frame_close();
    endtask

    task automatic send_end();
        frame_open(8'h53);
        spi_byte(8'h00);
        frame_close();
    endtask

    task automatic wait_idle(input int which, output bit ok);
        logic dl;
        ok = 1'b0;
        for (int i = 0; i < 500; i++) begin
            case (which)
                0:       dl = dl_8;
                1:       dl = dl_16;
                default: dl = dl_w;
            endcase
            if (dl === 1'b0) begin
                ok = 1'b1;
                break;
            end
            wait_clks(1);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        wait_clks(3);
        checks++; if (dl_8 !== 1'b0)    begin errors++; $display("FAIL reset_downloading: got %0b want 0", dl_8); end
        checks++; if (idx_8 !== 8'h00)  begin errors++; $display("FAIL reset_index: got %h want 00", idx_8); end
        checks++; if (size_8 !== 24'd0) begin errors++; $display("FAIL reset_size: got %0d want 0", size_8); end
        checks++; if (valid_8 !== 1'b0) begin errors++; $display("FAIL reset_wr_valid: got %0b want 0", valid_8); end
        checks++; if (ovf_8 !== 1'b0)   begin errors++; $display("FAIL reset_overflow: got %0b want 0", ovf_8); end
        checks++; if (addr_8 !== 16'd0) begin errors++; $display("FAIL reset_wr_addr: got %0d want 0", addr_8); end
        checks++; if (data_8 !== 8'h00) begin errors++; $display("FAIL reset_wr_data: got %h want 00", data_8); end
        checks++; if (mask_8 !== 1'b0)  begin errors++; $display("FAIL reset_wr_mask: got %b want 0", mask_8); end
        checks++; if (addr_w !== 4'd14) begin errors++; $display("FAIL reset_wr_addr_start: got %0d want 14", addr_w); end
        reset_n = 1'b1;
        wait_clks(6);
    endtask

    task automatic test_basic8();
        bit ok;
        logic [7:0] exp_d [3] = '{8'h11, 8'h22, 8'h33};
        sel = 2'd0;
        q8.delete();
        send_index(8'h07);
        checks++; if (idx_8 !== 8'h07) begin errors++; $display("FAIL basic_index: got %h want 07", idx_8); end
        send_start();
        checks++; if (dl_8 !== 1'b1) begin errors++; $display("FAIL basic_downloading: got %0b want 1", dl_8); end
        frame_open(8'h54);
        spi_byte(8'h11);
        spi_byte(8'h22);
        spi_byte(8'h33);
        frame_close();
        send_end();
        wait_idle(0, ok);
        checks++; if (!ok) begin errors++; $display("FAIL basic_idle: downloading still %0b want 0", dl_8); end
        checks++; if (size_8 !== 24'd3) begin errors++; $display("FAIL basic_size: got %0d want 3", size_8); end
        checks++; if (q8.size() != 3) begin errors++; $display("FAIL basic_count: got %0d writes want 3", q8.size()); end
        for (int i = 0; i < 3 && i < q8.size(); i++) begin
            checks++;
            if (q8[i].addr !== 16'(i) || q8[i].data !== 32'(exp_d[i]) || q8[i].mask !== 4'h1) begin
                errors++;
                $display("FAIL basic_write%0d: got addr %0d data %h mask %b want addr %0d data %h mask 1",
                         i, q8[i].addr, q8[i].data, q8[i].mask, i, exp_d[i]);
            end
        end
    endtask

    task automatic test_pack16();
        bit ok;
        sel = 2'd1;
        q16.delete();
        send_start();
        frame_open(8'h54);
        spi_byte(8'hAA);
        spi_byte(8'hBB);
        spi_byte(8'hCC);
        frame_close();
        send_end();
        wait_idle(1, ok);
        checks++; if (!ok) begin errors++; $display("FAIL pack16_idle: downloading still %0b want 0", dl_16); end
        checks++; if (size_16 !== 24'd3) begin errors++; $display("FAIL pack16_size: got %0d want 3", size_16); end
        checks++; if (q16.size() != 2) begin errors++; $display("FAIL pack16_count: got %0d writes want 2", q16.size()); end
        if (q16.size() >= 2) begin
            checks++;
            if (q16[0].addr !== 16'd0 || q16[0].data !== 32'h0000BBAA || q16[0].mask !== 4'b0011) begin
                errors++;
                $display("FAIL pack16_word0: got addr %0d data %h mask %b want addr 0 data bbaa mask 11",
                         q16[0].addr, q16[0].data, q16[0].mask);
            end
            checks++;
            if (q16[1].addr !== 16'd1 || q16[1].data !== 32'h000000CC || q16[1].mask !== 4'b0001) begin
                errors++;
                $display("FAIL pack16_word1: got addr %0d data %h mask %b want addr 1 data 00cc mask 01",
                         q16[1].addr, q16[1].data, q16[1].mask);
            end
        end
    endtask

    task automatic test_overflow();
        bit ok;
        sel = 2'd0;
        q8.delete();
        ready_8 = 1'b0;
        send_start();
        frame_open(8'h54);
        for (int b = 1; b <= 6; b++) spi_byte(8'(b));
        frame_close();
        checks++; if (valid_8 !== 1'b1)  begin errors++; $display("FAIL ovf_valid: got %0b want 1", valid_8); end
        checks++; if (ovf_8 !== 1'b1)    begin errors++; $display("FAIL ovf_flag: got %0b want 1", ovf_8); end
        checks++; if (size_8 !== 24'd6)  begin errors++; $display("FAIL ovf_size: got %0d want 6", size_8); end
        checks++; if (addr_8 !== 16'd0 || data_8 !== 8'h01)
            begin errors++; $display("FAIL ovf_head: got addr %0d data %h want addr 0 data 01", addr_8, data_8); end
        wait_clks(10);
        checks++; if (addr_8 !== 16'd0 || data_8 !== 8'h01 || mask_8 !== 1'b1)
            begin errors++; $display("FAIL ovf_head_stable: got addr %0d data %h mask %b want 0 01 1", addr_8, data_8, mask_8); end
        ready_8 = 1'b1;
        wait_clks(10);
        checks++; if (q8.size() != 4) begin errors++; $display("FAIL ovf_drained: got %0d writes want 4", q8.size()); end
        for (int i = 0; i < 4 && i < q8.size(); i++) begin
            checks++;
            if (q8[i].addr !== 16'(i) || q8[i].data !== 32'(i + 1)) begin
                errors++;
                $display("FAIL ovf_write%0d: got addr %0d data %h want addr %0d data %h",
                         i, q8[i].addr, q8[i].data, i, i + 1);
            end
        end
        frame_open(8'h54);
        spi_byte(8'h07);
        frame_close();
        send_end();
        wait_idle(0, ok);
        checks++; if (!ok) begin errors++; $display("FAIL ovf_idle: downloading still %0b want 0", dl_8); end
        checks++; if (q8.size() != 5) begin errors++; $display("FAIL ovf_count: got %0d writes want 5", q8.size()); end
        if (q8.size() >= 5) begin
            checks++;
            if (q8[4].addr !== 16'd6 || q8[4].data !== 32'h07) begin
                errors++;
                $display("FAIL ovf_next_addr: got addr %0d data %h want addr 6 data 07", q8[4].addr, q8[4].data);
            end
        end
        checks++; if (size_8 !== 24'd7) begin errors++; $display("FAIL ovf_size_final: got %0d want 7", size_8); end
        checks++; if (ovf_8 !== 1'b1)   begin errors++; $display("FAIL ovf_sticky: got %0b want 1", ovf_8); end
    endtask

    task automatic test_wrap();
        bit ok;
        logic [15:0] exp_a [4] = '{16'd14, 16'd15, 16'd0, 16'd1};
        sel = 2'd2;
        qw.delete();
        send_start();
        frame_open(8'h54);
        for (int b = 0; b < 4; b++) spi_byte(8'hA0 + 8'(b));
        frame_close();
        send_end();
        wait_idle(2, ok);
        checks++; if (!ok) begin errors++; $display("FAIL wrap_idle: downloading still %0b want 0", dl_w); end
        checks++; if (qw.size() != 4) begin errors++; $display("FAIL wrap_count: got %0d writes want 4", qw.size()); end
        for (int i = 0; i < 4 && i < qw.size(); i++) begin
            checks++;
            if (qw[i].addr !== exp_a[i] || qw[i].data !== 32'(8'hA0 + 8'(i))) begin
                errors++;
                $display("FAIL wrap_write%0d: got addr %0d data %h want addr %0d data %h",
                         i, qw[i].addr, qw[i].data, exp_a[i], 8'hA0 + 8'(i));
            end
        end
    endtask

    task automatic test_partial_frame();
        bit ok;
        sel = 2'd0;
        q8.delete();
        send_start();
        checks++; if (ovf_8 !== 1'b0) begin errors++; $display("FAIL partial_ovf_cleared: got %0b want 0", ovf_8); end
        frame_open(8'h54);
        spi_byte(8'h10);
        for (int i = 0; i < 5; i++) spi_bit(1'b1);
        frame_close();
        frame_open(8'h54);
        spi_byte(8'h5A);
        frame_close();
        send_index(8'h99);
        checks++; if (idx_8 !== 8'h07) begin errors++; $display("FAIL partial_index_locked: got %h want 07", idx_8); end
        send_end();
        wait_idle(0, ok);
        checks++; if (!ok) begin errors++; $display("FAIL partial_idle: downloading still %0b want 0", dl_8); end
        checks++; if (size_8 !== 24'd2) begin errors++; $display("FAIL partial_size: got %0d want 2", size_8); end
        checks++; if (q8.size() != 2) begin errors++; $display("FAIL partial_count: got %0d writes want 2", q8.size()); end
        if (q8.size() >= 2) begin
            checks++;
            if (q8[0].addr !== 16'd0 || q8[0].data !== 32'h10 || q8[1].addr !== 16'd1 || q8[1].data !== 32'h5A) begin
                errors++;
                $display("FAIL partial_writes: got (%0d,%h) (%0d,%h) want (0,10) (1,5a)",
                         q8[0].addr, q8[0].data, q8[1].addr, q8[1].data);
            end
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        sel = 2'd0;
        q8.delete();
        ready_8 = 1'b0;
        send_start();
        frame_open(8'h54);
        spi_byte(8'hC1);
        spi_byte(8'hC2);
        for (int i = 0; i < 3; i++) spi_bit(1'b0);
        checks++; if (valid_8 !== 1'b1) begin errors++; $display("FAIL rstmid_queued: got %0b want 1", valid_8); end
        reset_n = 1'b0;
        #1;
        checks++; if (valid_8 !== 1'b0)  begin errors++; $display("FAIL rstmid_valid: got %0b want 0", valid_8); end
        checks++; if (dl_8 !== 1'b0)     begin errors++; $display("FAIL rstmid_downloading: got %0b want 0", dl_8); end
        checks++; if (size_8 !== 24'd0)  begin errors++; $display("FAIL rstmid_size: got %0d want 0", size_8); end
        checks++; if (idx_8 !== 8'h00)   begin errors++; $display("FAIL rstmid_index: got %h want 00", idx_8); end
        ss = 1'b1;
        wait_clks(3);
        reset_n = 1'b1;
        wait_clks(6);
        ready_8 = 1'b1;
        send_start();
        frame_open(8'h54);
        spi_byte(8'h77);
        frame_close();
        send_end();
        wait_idle(0, ok);
        checks++; if (!ok) begin errors++; $display("FAIL rstmid_idle: downloading still %0b want 0", dl_8); end
        checks++; if (q8.size() != 1) begin errors++; $display("FAIL rstmid_count: got %0d writes want 1", q8.size()); end
        if (q8.size() >= 1) begin
            checks++;
            if (q8[0].addr !== 16'd0 || q8[0].data !== 32'h77 || q8[0].mask !== 4'h1) begin
                errors++;
                $display("FAIL rstmid_write: got addr %0d data %h mask %b want addr 0 data 77 mask 1",
                         q8[0].addr, q8[0].data, q8[0].mask);
            end
        end
    endtask

    initial begin
        reset_n  = 1'b0;
        sck      = 1'b0;
        ss       = 1'b1;
        sdi      = 1'b0;
        sel      = 2'd0;
        ready_8  = 1'b1;
        ready_16 = 1'b1;
        ready_w  = 1'b1;
        test_reset();
        test_basic8();
        test_pack16();
        test_overflow();
        test_wrap();
        test_partial_frame();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/data_io_stream.md
Name: data_io_stream

Overview:
- Parametrised successor to the MiST IO-controller download port.
- Receives a file from the IO controller over the dedicated SPI link (UIO_FILE_INDEX / UIO_FILE_TX / UIO_FILE_TX_DAT commands), oversampling it in the core clock domain.
- Packs bytes into DATA_W-bit little-endian words and delivers them through a valid/ready write port buffered by a small FIFO.
- Sits between the SPI pins and core-side loaders (ROM/cart RAM/SDRAM writers), replacing the fixed 8-bit/8 KB embedded RAM scheme.

Parameters:
- ADDR_W, 16, width of the word address wr_addr.
- DATA_W, 8, output word width; allowed values 8, 16, 32.
- START_ADDR, 0, word address of the first word of every download.
- FIFO_DEPTH, 4, output FIFO entries; must be a power of two, at least 2.
- SIZE_W, 24, width of the byte counter.

Ports:
- clk  in  1  core clock; must run at least 4x sck.
- reset_n  in  1  asynchronous active-low reset.
- sck  in  1  SPI clock from IO controller; asynchronous to clk.
- ss  in  1  SPI select, active high = idle; asynchronous.
- sdi  in  1  SPI data, MSB first; asynchronous.
- downloading  out  1  high while a download is active or undrained.
- index  out  8  file index from the last UIO_FILE_INDEX command.
- size  out  SIZE_W  bytes received since the last start; saturates at all ones.
- wr_valid  out  1  FIFO head valid.
- wr_ready  in  1  consumer accepts the head this cycle.
- wr_addr  out  ADDR_W  word address of the head.
- wr_data  out  DATA_W  head data; byte lane 0 holds the earliest byte.
- wr_mask  out  DATA_W/8  byte-lane enables for the head; all ones except on a flushed final word.
- overflow  out  1  sticky: a word was dropped because the FIFO was full.

Behaviour:
- Reset (async assert, sync deassert):
  - outputs: downloading=0, index=0, size=0, wr_valid=0, overflow=0, wr_addr=START_ADDR, wr_data=0, wr_mask=0.
  - internal: FIFO empty, packer empty, bit counter 0, cmd=0.
  - reset mid-download discards everything; no flush.
- Synchronisation:
  - sck, ss and sdi each pass through two flops.
  - A bit is sampled on the clk cycle where synced sck goes 0->1 while synced ss=0.
- Framing:
  - Synced ss=1 clears the bit counter and cmd; a partial byte is discarded.
  - The packer and address state are kept across frames.
  - Within a frame, bits 0-7 form cmd. Every following 8 bits form a parameter byte, repeating until ss rises.
- Commands (constants from the package):
  - UIO_FILE_INDEX 0x55: each parameter byte is written to index, only while downloading=0; ignored otherwise.
  - UIO_FILE_TX 0x53, parameter bit0=1 (start): size<=0, overflow<=0, packer cleared, next word address <= START_ADDR, downloading<=1. A start while already downloading restarts with the same actions, and FIFO contents are flushed.
  - UIO_FILE_TX 0x53, parameter bit0=0 (end): if the packer holds k bytes (0<k<DATA_W/8), push one word with wr_mask lanes 0..k-1 set and the other lanes' data 0. Then enter DRAIN.
  - UIO_FILE_TX_DAT 0x54: each byte goes into the packer only when downloading=1 and not in DRAIN; size increments by 1, saturating.
  - All other commands are ignored.
- Packing:
  - A byte goes into lane n, then n increments.
  - When lane DATA_W/8-1 is filled, the word is pushed with mask all ones, and the address increments modulo 2^ADDR_W.
  - For DATA_W=8, every byte is pushed immediately.
- Timing and latency:
  - A byte completes on sample cycle N.
  - Push into the FIFO happens at cycle N+1.
  - wr_valid rises at N+2 if the FIFO was empty.
- Handshake:
  - The head pops on wr_valid && wr_ready.
  - wr_addr, wr_data and wr_mask stay stable while wr_valid=1 and wr_ready=0.
- FIFO boundaries:
  - A push when full with no pop that cycle drops the word and sets overflow. The address still advances.
  - A push when full with a pop in the same cycle is accepted.
  - A push and pop when empty: the word becomes head next cycle; no bypass.
- States (control FSM):
  - IDLE -> ACTIVE on start.
  - ACTIVE -> FLUSH on end, only if the packer is non-empty.
  - ACTIVE -> DRAIN on end with an empty packer.
  - FLUSH -> DRAIN after one cycle (the push).
  - DRAIN -> IDLE when the FIFO is empty; downloading falls on that transition.
  - A start received in any state goes to ACTIVE.

Decomposition:
- Package data_io_pkg:
  - command constants UIO_FILE_TX, UIO_FILE_TX_DAT, UIO_FILE_INDEX.
  - FSM state enum (IDLE, ACTIVE, FLUSH, DRAIN).
  - a function for the byte-lane count.
- One sub-module, data_io_fifo: synchronous FIFO, FIFO_DEPTH x (ADDR_W+DATA_W+DATA_W/8), with push/pop/full/empty and flush.
- SPI sampler, command decoder, packer and FSM stay in the top module.

Test Plan:
- DATA_W=8: index 0x07, start, bytes 0x11 0x22 0x33, end, wr_ready=1 -> index=0x07; three writes, addr 0,1,2, data 0x11/0x22/0x33, mask 1; size=3; downloading falls after the last pop.
- DATA_W=16: start, bytes AA BB CC, end -> writes (addr 0, data 0xBBAA, mask 2'b11) then (addr 1, data 0x00CC, mask 2'b01).
- FIFO_DEPTH=4, DATA_W=8, wr_ready=0: six bytes -> four entries held, overflow=1, size=6. Then wr_ready=1 -> addresses 0..3 popped; the next byte lands at addr 6.
- ADDR_W=4, START_ADDR=14, DATA_W=8: four bytes -> addr 14,15,0,1.
- ss raised after 5 bits of a data byte, then a new 0x54 frame with byte 0x5A -> the partial byte is discarded; the next write is 0x5A at the next address. Index command during download -> index unchanged.
- Assert reset_n=0 mid-frame with 2 entries queued -> wr_valid=0, downloading=0, size=0 in the same cycle. A subsequent start works normally from addr START_ADDR.
